// File: rtl/lsu_align_pipe.sv
// Load/store alignment pipeline between execute and data memory.
// S1 holds the accepted request and issues the memory access; S2 waits for the
// synchronous read data, holds it under backpressure and extends the load result.
module lsu_align_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_load,
  input  logic                in_store,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic                out_misaligned
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);

  typedef enum logic [1:0] {StEmpty, StFresh, StHeld} s2_state_e;

  // S1 request register
  logic            r_s1_valid;
  logic            r_s1_load;
  logic            r_s1_store;
  logic [1:0]      r_s1_size;
  logic            r_s1_unsigned;
  logic [XLEN-1:0] r_s1_addr;
  logic [XLEN-1:0] r_s1_wdata;

  // S2 state
  s2_state_e       r_s2_state;
  logic            r_s2_load;
  logic            r_s2_mis;
  logic [1:0]      r_s2_size;
  logic            r_s2_unsigned;
  logic [LW-1:0]   r_s2_lane;
  logic [XLEN-1:0] r_hold;

  logic            w_mis;
  logic            w_access;
  logic            w_s1_adv;
  logic            w_mem_req;
  logic [LW-1:0]   w_s1_lane;
  logic [3:0]      w_num_bytes;
  logic [NB-1:0]   w_be_mask;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_sh;
  logic [6:0]      w_bits;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_top;
  logic            w_sign;
  logic [XLEN-1:0] w_ext;

  assign w_s1_lane = r_s1_addr[LW-1:0];
  assign w_access  = r_s1_load | r_s1_store;

  // Alignment check on the S1 request; dword on a 32-bit datapath is never legal
  always_comb begin
    w_mis = 1'b0;
    unique case (r_s1_size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = r_s1_addr[0];
      2'b10:   w_mis = |r_s1_addr[1:0];
      default: w_mis = (XLEN == 32) ? 1'b1 : |r_s1_addr[2:0];
    endcase
  end

  assign out_valid = (r_s2_state != StEmpty);
  // S1 may move on when S2 is free or S2 is being consumed; nothing moves during reset
  assign w_s1_adv  = !Reset & r_s1_valid & ((r_s2_state == StEmpty) | (out_valid & out_ready));
  assign in_ready  = Reset | !r_s1_valid | w_s1_adv;
  assign w_mem_req = w_s1_adv & !w_mis & w_access;

  // Memory request decode: byte-enable mask and lane-shifted write data
  always_comb begin
    w_num_bytes = 4'd1 << r_s1_size;
    w_be_mask   = ~({NB{1'b1}} << w_num_bytes);
    mem_req     = w_mem_req;
    mem_we      = w_mem_req & r_s1_store;
    mem_addr    = w_mem_req ? {r_s1_addr[XLEN-1:LW], {LW{1'b0}}} : '0;
    mem_be      = (w_mem_req & r_s1_store) ? (w_be_mask << w_s1_lane) : '0;
    mem_wdata   = (w_mem_req & r_s1_store) ? (r_s1_wdata << {w_s1_lane, 3'b000}) : '0;
  end

  // S1 register: load on accept, drain when handed to S2
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_load     <= 1'b0;
      r_s1_store    <= 1'b0;
      r_s1_size     <= 2'b00;
      r_s1_unsigned <= 1'b0;
      r_s1_addr     <= '0;
      r_s1_wdata    <= '0;
    end else if (in_valid & in_ready) begin
      r_s1_valid    <= 1'b1;
      r_s1_load     <= in_load;
      r_s1_store    <= in_store;
      r_s1_size     <= in_size;
      r_s1_unsigned <= in_unsigned;
      r_s1_addr     <= in_addr;
      r_s1_wdata    <= in_wdata;
    end else if (w_s1_adv) begin
      r_s1_valid    <= 1'b0;
    end
  end

  // S2 FSM: capture request info on advance, park read data in r_hold when stalled
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s2_state    <= StEmpty;
      r_s2_load     <= 1'b0;
      r_s2_mis      <= 1'b0;
      r_s2_size     <= 2'b00;
      r_s2_unsigned <= 1'b0;
      r_s2_lane     <= '0;
      r_hold        <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s2_load     <= r_s1_load & !w_mis;
        r_s2_mis      <= w_mis & w_access;
        r_s2_size     <= r_s1_size;
        r_s2_unsigned <= r_s1_unsigned;
        r_s2_lane     <= w_s1_lane;
      end
      unique case (r_s2_state)
        StEmpty: if (w_s1_adv) r_s2_state <= StFresh;
        StFresh: begin
          if (out_ready) begin
            r_s2_state <= w_s1_adv ? StFresh : StEmpty;
          end else begin
            r_hold     <= mem_rdata;
            r_s2_state <= StHeld;
          end
        end
        StHeld: if (out_ready) r_s2_state <= w_s1_adv ? StFresh : StEmpty;
        default: r_s2_state <= StEmpty;
      endcase
    end
  end

  // Load extraction: lane shift, then mask and sign-fill above the access width
  always_comb begin
    w_src  = (r_s2_state == StHeld) ? r_hold : mem_rdata;
    w_sh   = w_src >> {r_s2_lane, 3'b000};
    w_bits = 7'd8 << r_s2_size;
    // Shift by the full width yields zero, so a full-width access masks everything in
    w_mask = ~({XLEN{1'b1}} << w_bits);
    w_top  = w_mask & ~(w_mask >> 1);
    w_sign = |(w_sh & w_top);
    w_ext  = (w_sh & w_mask) | ((w_sign & !r_s2_unsigned) ? ~w_mask : '0);
    out_result     = (out_valid & r_s2_load) ? w_ext : '0;
    out_misaligned = out_valid & r_s2_mis;
  end

endmodule

// File: tb/tb_lsu_align_pipe.sv
// Directed bench for lsu_align_pipe: 32-bit instance for the main paths and a
// 64-bit instance for dword and upper-word extraction.
module tb_lsu_align_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  always #5 Clk = ~Clk;

  // 32-bit DUT signals
  logic        in_valid, in_ready, in_load, in_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        out_valid, out_ready, out_misaligned;
  logic [31:0] out_result;

  // 64-bit DUT signals
  logic        d_in_valid, d_in_ready, d_in_load, d_in_store, d_in_unsigned;
  logic [1:0]  d_in_size;
  logic [63:0] d_in_addr, d_in_wdata;
  logic        d_mem_req, d_mem_we;
  logic [63:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic [7:0]  d_mem_be;
  logic        d_out_valid, d_out_ready, d_out_misaligned;
  logic [63:0] d_out_result;
  logic [63:0] d_val;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int base;
  logic [31:0] mem32 [16];

  lsu_align_pipe #(.XLEN(32)) u_dut32 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_misaligned(out_misaligned)
  );

  lsu_align_pipe #(.XLEN(64)) u_dut64 (
    .Clk(Clk), .Reset(Reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_load(d_in_load), .in_store(d_in_store), .in_size(d_in_size),
    .in_unsigned(d_in_unsigned), .in_addr(d_in_addr), .in_wdata(d_in_wdata),
    .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_be(d_mem_be),
    .mem_wdata(d_mem_wdata), .mem_rdata(d_mem_rdata), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_result(d_out_result), .out_misaligned(d_out_misaligned)
  );

  // Synchronous-read memory models; garbage when not reading so stale data shows up
  always @(posedge Clk) begin
    if (mem_req) n_req <= n_req + 1;
    mem_rdata   <= (mem_req && !mem_we) ? mem32[mem_addr[5:2]] : 32'hDEAD_BEEF;
    d_mem_rdata <= (d_mem_req && !d_mem_we) ? d_val : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ld(input logic [31:0] addr);
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
    in_size = 2'b10; in_unsigned = 1'b0; in_addr = addr; in_wdata = '0;
  endtask

  // One request through the 32-bit unit with out_ready high
  task automatic run32(input string tag, input logic ld, input logic st,
                       input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic ereq,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] eres, input logic emis);
    @(negedge Clk);
    mem32[addr[5:2]] = rd;
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz;
    in_unsigned = uns; in_addr = addr; in_wdata = wd;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge Clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_mem_req"}, mem_req, ereq);
    chk({tag, "_mem_we"}, mem_we, ereq & st);
    chk({tag, "_mem_addr"}, mem_addr, ereq ? {addr[31:2], 2'b00} : 32'h0);
    chk({tag, "_mem_be"}, mem_be, ebe);
    chk({tag, "_mem_wdata"}, mem_wdata, ewd);
    @(negedge Clk);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_result"}, out_result, eres);
    chk({tag, "_out_mis"}, out_misaligned, emis);
  endtask

  task automatic run64(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] val,
                       input logic ereq, input logic [63:0] eres, input logic emis);
    @(negedge Clk);
    d_val = val;
    d_in_valid = 1'b1; d_in_load = 1'b1; d_in_store = 1'b0; d_in_size = sz;
    d_in_unsigned = uns; d_in_addr = addr; d_in_wdata = '0;
    @(negedge Clk);
    d_in_valid = 1'b0;
    #1;
    chk({tag, "_mem_req"}, d_mem_req, ereq);
    chk({tag, "_mem_addr"}, d_mem_addr, ereq ? {addr[63:3], 3'b000} : 64'h0);
    @(negedge Clk);
    chk({tag, "_out_valid"}, d_out_valid, 1);
    chk({tag, "_out_result"}, d_out_result, eres);
    chk({tag, "_out_mis"}, d_out_misaligned, emis);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; out_ready = 1;
    d_in_valid = 0; d_in_load = 0; d_in_store = 0; d_in_size = 0; d_in_unsigned = 0;
    d_in_addr = 0; d_in_wdata = 0; d_out_ready = 1; d_val = 0;
    for (int i = 0; i < 16; i++) mem32[i] = 32'h0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_mis", out_misaligned, 0);

    // Stores
    run32("st_byte", 0, 1, 2'b00, 0, 32'h103, 32'h0000_00AB, 32'h0, 1, 4'b1000,
          32'hAB00_0000, 32'h0, 0);
    run32("st_half", 0, 1, 2'b01, 0, 32'h202, 32'hFFFF_1234, 32'h0, 1, 4'b1100,
          32'h1234_0000, 32'h0, 0);
    run32("st_half_mis", 0, 1, 2'b01, 0, 32'h201, 32'h0000_1234, 32'h0, 0, 4'b0000,
          32'h0, 32'h0, 1);
    // Loads
    run32("ld_half_s", 1, 0, 2'b01, 0, 32'h2, 32'h0, 32'h8001_1234, 1, 4'b0000,
          32'h0, 32'hFFFF_8001, 0);
    run32("ld_half_u", 1, 0, 2'b01, 1, 32'h2, 32'h0, 32'h8001_1234, 1, 4'b0000,
          32'h0, 32'h0000_8001, 0);
    run32("ld_byte_s", 1, 0, 2'b00, 0, 32'h11, 32'h0, 32'h1234_F600, 1, 4'b0000,
          32'h0, 32'hFFFF_FFF6, 0);
    run32("ld_word", 1, 0, 2'b10, 1, 32'h14, 32'h0, 32'h8765_4321, 1, 4'b0000,
          32'h0, 32'h8765_4321, 0);
    run32("ld_word_mis", 1, 0, 2'b10, 0, 32'h6, 32'h0, 32'h1111_1111, 0, 4'b0000,
          32'h0, 32'h0, 1);
    run32("ld_dword32", 1, 0, 2'b11, 0, 32'h8, 32'h0, 32'h2222_2222, 0, 4'b0000,
          32'h0, 32'h0, 1);
    run32("nop", 0, 0, 2'b10, 0, 32'h8, 32'h0, 32'h3333_3333, 0, 4'b0000,
          32'h0, 32'h0, 0);

    // Backpressure: four back-to-back word loads, stall after the first result
    for (int i = 1; i <= 4; i++) mem32[i] = 32'hC0DE_0000 + i;
    @(negedge Clk);
    base = n_req;
    drive_ld(32'h4);
    @(negedge Clk);
    drive_ld(32'h8);
    @(negedge Clk);
    drive_ld(32'hC);
    #1 chk("bp_r0", out_result, 32'hC0DE_0001);
    @(negedge Clk);
    out_ready = 1'b0;
    drive_ld(32'h10);
    #1;
    chk("bp_fresh_r1", out_result, 32'hC0DE_0002);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_no_req", mem_req, 0);
    @(negedge Clk);
    #1;
    chk("bp_held1", out_result, 32'hC0DE_0002);
    chk("bp_held1_valid", out_valid, 1);
    @(negedge Clk);
    #1 chk("bp_held2", out_result, 32'hC0DE_0002);
    @(negedge Clk);
    out_ready = 1'b1;
    #1;
    chk("bp_held3", out_result, 32'hC0DE_0002);
    chk("bp_resume_req", mem_req, 1);
    chk("bp_resume_ready", in_ready, 1);
    @(negedge Clk);
    in_valid = 1'b0;
    #1 chk("bp_r2", out_result, 32'hC0DE_0003);
    @(negedge Clk);
    #1 chk("bp_r3", out_result, 32'hC0DE_0004);
    @(negedge Clk);
    #1;
    chk("bp_drained", out_valid, 0);
    chk("bp_req_count", n_req - base, 4);

    // Reset with S1 and S2 both occupied
    @(negedge Clk);
    drive_ld(32'h4);
    @(negedge Clk);
    out_ready = 1'b0;
    drive_ld(32'h8);
    @(negedge Clk);
    in_valid = 1'b0;
    Reset = 1'b1;
    base = n_req;
    #1 chk("rstmid_req_in_reset", mem_req, 0);
    @(negedge Clk);
    Reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_in_ready", in_ready, 1);
    @(negedge Clk);
    #1 chk("rstmid_no_stale_req", n_req - base, 0);
    run32("rstmid_ld", 1, 0, 2'b00, 1, 32'h23, 32'h0, 32'h9A00_0000, 1, 4'b0000,
          32'h0, 32'h0000_009A, 0);

    // 64-bit datapath
    run64("x64_dword", 2'b11, 0, 64'h8, 64'h8123_4567_89AB_CDEF, 1,
          64'h8123_4567_89AB_CDEF, 0);
    run64("x64_word_s", 2'b10, 0, 64'h4, 64'h8000_0000_0000_0000, 1,
          64'hFFFF_FFFF_8000_0000, 0);
    run64("x64_word_u", 2'b10, 1, 64'h4, 64'h8000_0000_0000_0000, 1,
          64'h0000_0000_8000_0000, 0);
    run64("x64_dword_mis", 2'b11, 0, 64'h4, 64'h1, 0, 64'h0, 1);

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_align_pipe.md
Name: lsu_align_pipe

Overview:
- Parametrised, pipelined successor to the combinational decode/extract logic.
- Sits between the execute stage and data memory and handles all load/store width handling.
- Store path: generates per-byte write enables and lane-shifted store data.
- Load path: extracts and sign/zero-extends byte/half/word(/dword) results from synchronous-read memory. Valid/ready handshakes on both sides; misaligned accesses are flagged.

Parameters:
- XLEN, 32, datapath width in bits; legal values 32 or 64.
- NB, XLEN/8, byte lanes (derived; do not override).
- LW, log2(NB), lane-offset bits of address (derived).

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request this cycle
- in_load  in  1  request is a load
- in_store  in  1  request is a store (in_load and in_store both 0 = bubble, passes through as no-op)
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when XLEN=64)
- in_unsigned  in  1  zero-extend load result when 1
- in_addr  in  XLEN  byte address
- in_wdata  in  XLEN  store data, right-justified
- mem_req  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write when 1
- mem_addr  out  XLEN  address with low LW bits forced to 0
- mem_be  out  NB  byte write enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rdata  in  XLEN  read word; valid the cycle after mem_req
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  XLEN  extended load result (0 for stores/no-ops)
- out_misaligned  out  1  access was misaligned and not issued

Behaviour:
- Reset: S1/S2 cleared, state EMPTY. All outputs 0 except in_ready=1. Reset mid-transaction discards in-flight requests; no mem_req is issued in the reset cycle.
- S1 register:
  - Loads on in_valid & in_ready.
  - in_ready = !s1_valid | s1_adv.
  - s1_adv = s1_valid & (s2_state==EMPTY | (out_valid & out_ready)).
- Alignment:
  - Misaligned when (half & addr[0]), (word & addr[1:0]!=0), or (dword & addr[2:0]!=0).
  - size 11 with XLEN=32 is treated as misaligned.
- mem_req = s1_adv & !misaligned & (load|store), combinational from S1.
  - mem_we = store.
  - mem_be = size mask (0x1/0x3/0xF/0xFF) shifted left by addr[LW-1:0].
  - mem_wdata = in_wdata shifted left by 8*addr[LW-1:0].
  - Loads drive mem_be = 0.
- S2 state machine: EMPTY, FRESH, HELD.
  - EMPTY -> FRESH on s1_adv.
  - FRESH: out_valid=1; load result from mem_rdata.
    - If out_ready & s1_adv: stay FRESH.
    - If out_ready only: -> EMPTY.
    - Else: latch mem_rdata into hold register -> HELD.
  - HELD: out_valid=1; result from hold register. -> FRESH or EMPTY on out_ready, using the same rule as FRESH.
- Load extraction:
  - Shift mem_rdata right by 8*addr lane.
  - Take 8/16/32/64 bits; sign-extend unless unsigned.
  - Word on XLEN=32 and dword ignore in_unsigned.
- Stores, no-ops and misaligned accesses: out_result = 0. out_misaligned = 1 only for misaligned load/store.
- Latency: request to out_valid = 2 cycles.
- Throughput: 1 per cycle when out_ready is held high.
- Backpressure: no request is lost or duplicated; mem_req is never asserted twice for one request.

Test Plan:
- XLEN=32 store byte: addr 0x103, wdata 0x000000AB -> mem_be=1000, mem_wdata=0xAB000000, mem_addr=0x100, out_result=0, out_misaligned=0.
- Signed load half: addr 0x2, mem_rdata 0x8001_1234 -> out_result=0xFFFF8001 two cycles after accept; repeat with unsigned -> 0x00008001.
- Misaligned word load: addr 0x6 -> no mem_req, out_valid after 2 cycles, out_misaligned=1, out_result=0.
- Backpressure: 4 back-to-back loads, out_ready low 3 cycles after first result -> HELD value stable; in_ready=0 once S1 is full; exactly 4 mem_req and 4 in-order results.
- Reset asserted while S1 and S2 are both valid -> next cycle out_valid=0, mem_req=0, in_ready=1; subsequent load completes normally.
- XLEN=64: dword load at addr 0x8 -> mem_rdata passed through. Word load at 0x4 of 0x80000000_00000000 -> 0xFFFFFFFF_80000000.
